// File: rtl/regfile_sb.sv
// regfile_sb: multi-read dual-write register file with write-through bypass and pending-load scoreboard
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int RD_PORTS = 2,
   parameter int BYPASS   = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we0,
   input  logic [ADDR_W-1:0]            wa0,
   input  logic [DATA_W-1:0]            wd0,
   input  logic                         we1,
   input  logic [ADDR_W-1:0]            wa1,
   input  logic [DATA_W-1:0]            wd1,
   input  logic [RD_PORTS*ADDR_W-1:0]   ra,
   output logic [RD_PORTS*DATA_W-1:0]   rd,
   output logic [RD_PORTS-1:0]          rbusy,
   input  logic                         set_busy,
   input  logic [ADDR_W-1:0]            set_addr,
   output logic [ADDR_W:0]              busy_cnt
);
   localparam int DEPTH = 1 << ADDR_W;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic              w0_hit, w1_hit, set_hit, inc, dec;
   assign w1_hit  = we1 && wa1 != '0;
   assign w0_hit  = we0 && wa0 != '0 && !(w1_hit && wa1 == wa0);
   assign set_hit = set_busy && set_addr != '0;
   assign inc     = set_hit && !busy[set_addr];
   assign dec     = w1_hit && busy[wa1] && !(set_hit && set_addr == wa1);
   // storage update; port 1 wins a same-address collision, entry 0 is never written
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (w0_hit) mem[wa0] <= wd0;
         if (w1_hit) mem[wa1] <= wd1;
      end
   end
   // scoreboard: load return clears, load issue sets, a new issue beats a same-cycle return
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         if (w1_hit) busy[wa1] <= 1'b0;
         if (set_hit) busy[set_addr] <= 1'b1;
         busy_cnt <= busy_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
      end
   end
   for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      assign a = ra[k*ADDR_W +: ADDR_W];
      assign rd[k*DATA_W +: DATA_W] =
         (a == '0)                           ? '0  :
         (BYPASS != 0 && we1 && wa1 == a)    ? wd1 :
         (BYPASS != 0 && we0 && wa0 == a)    ? wd0 : mem[a];
      assign rbusy[k] = busy[a];
   end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed checks of regfile_sb against an array-based reference model
module tb_regfile_sb;
   localparam int DW = 32, AW = 5, RP = 4, N = 1 << AW;
   logic clk = 0, rst, we0, we1, set_busy;
   logic [AW-1:0] wa0, wa1, set_addr;
   logic [DW-1:0] wd0, wd1;
   logic [RP*AW-1:0] ra;
   logic [RP*DW-1:0] rd, rd_nb;
   logic [RP-1:0] rbusy, rbusy_nb;
   logic [AW:0] busy_cnt, busy_cnt_nb;
   logic [DW-1:0] m [N];
   bit b [N];
   int total = 0, bad = 0;
   always #5 clk = ~clk;
   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra(ra), .rd(rd), .rbusy(rbusy), .set_busy(set_busy), .set_addr(set_addr), .busy_cnt(busy_cnt));
   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .RD_PORTS(RP), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra(ra), .rd(rd_nb), .rbusy(rbusy_nb), .set_busy(set_busy), .set_addr(set_addr), .busy_cnt(busy_cnt_nb));
   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
      if (a == 0) return '0;
      if (byp && we1 && wa1 == a) return wd1;
      if (byp && we0 && wa0 == a) return wd0;
      return m[a];
   endfunction
   task automatic compare();
      int c = 0;
      foreach (b[i]) c += int'(b[i]);
      for (int k = 0; k < RP; k++) begin
         logic [AW-1:0] a = ra[k*AW +: AW];
         chk("rd_bypass", rd[k*DW +: DW], exp_rd(a, 1));
         chk("rd_nobypass", rd_nb[k*DW +: DW], exp_rd(a, 0));
         chk("rbusy", DW'(rbusy[k]), DW'(b[a]));
         chk("rbusy_nb", DW'(rbusy_nb[k]), DW'(b[a]));
      end
      chk("busy_cnt", DW'(busy_cnt), DW'(c));
      chk("busy_cnt_nb", DW'(busy_cnt_nb), DW'(c));
   endtask
   task automatic tick();
      #1 compare();
      @(posedge clk);
      if (rst) begin
         foreach (m[i]) begin m[i] = '0; b[i] = 0; end
      end else begin
         if (we0 && wa0 != 0 && !(we1 && wa1 == wa0)) m[wa0] = wd0;
         if (we1 && wa1 != 0) begin m[wa1] = wd1; b[wa1] = 0; end
         if (set_busy && set_addr != 0) b[set_addr] = 1;
      end
      @(negedge clk);
   endtask
   task automatic idle();
      rst = 0; we0 = 0; we1 = 0; set_busy = 0;
      wa0 = '0; wa1 = '0; set_addr = '0; wd0 = '0; wd1 = '0;
   endtask
   function automatic logic [AW-1:0] rnd_addr();
      return ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, N-1)) : AW'($urandom_range(0, 3));
   endfunction
   initial begin
      idle(); ra = '0; rst = 1;
      foreach (m[i]) begin m[i] = '0; b[i] = 0; end
      @(posedge clk); @(negedge clk);
      rst = 0;
      // reset discards a prior write and busy mark
      we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; set_busy = 1; set_addr = 5; tick();
      idle(); rst = 1; we1 = 1; wa1 = 6; wd1 = 32'h1234; tick();
      idle(); ra = {4{AW'(5)}}; #1;
      chk("rst_r5", rd[DW-1:0], 32'h0);
      chk("rst_rbusy", DW'(rbusy), 32'h0);
      chk("rst_cnt", DW'(busy_cnt), 32'h0);
      tick();
      // zero register
      we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; ra = '0; #1;
      chk("r0_same", rd[DW-1:0], 32'h0);
      chk("r0_same_p3", rd[3*DW +: DW], 32'h0);
      tick(); idle(); #1;
      chk("r0_next", rd[DW-1:0], 32'h0);
      tick();
      // collision with bypass
      we0 = 1; wa0 = 3; wd0 = 32'h11; we1 = 1; wa1 = 3; wd1 = 32'h22; ra = {4{AW'(3)}}; #1;
      chk("coll_byp_same", rd[DW-1:0], 32'h22);
      chk("coll_nb_same", rd_nb[DW-1:0], 32'h0);
      tick(); idle(); #1;
      chk("coll_byp_next", rd[DW-1:0], 32'h22);
      chk("coll_nb_next", rd_nb[DW-1:0], 32'h22);
      tick();
      // four-port read
      for (int i = 1; i <= 4; i++) begin
         we0 = 1; wa0 = AW'(i); wd0 = 32'hA0 + DW'(i); tick();
      end
      idle(); ra = {AW'(4), AW'(3), AW'(2), AW'(1)}; #1;
      for (int k = 0; k < RP; k++) chk("multiport", rd[k*DW +: DW], 32'hA1 + DW'(k));
      tick();
      // scoreboard lifecycle
      set_busy = 1; set_addr = 7; ra = {4{AW'(7)}}; tick();
      idle(); #1;
      chk("sb_busy", DW'(rbusy[0]), 32'h1);
      chk("sb_cnt1", DW'(busy_cnt), 32'h1);
      we1 = 1; wa1 = 7; wd1 = 32'h55; #1;
      chk("sb_nobypass_busy", DW'(rbusy[0]), 32'h1);
      tick(); idle(); #1;
      chk("sb_clear", DW'(rbusy[0]), 32'h0);
      chk("sb_cnt0", DW'(busy_cnt), 32'h0);
      chk("sb_data", rd_nb[DW-1:0], 32'h55);
      tick();
      // set/clear race
      set_busy = 1; set_addr = 9; ra = {4{AW'(9)}}; tick();
      idle(); set_busy = 1; set_addr = 9; we1 = 1; wa1 = 9; wd1 = 32'h99; tick();
      idle(); #1;
      chk("race_busy", DW'(rbusy[0]), 32'h1);
      chk("race_cnt", DW'(busy_cnt), 32'h1);
      we1 = 1; wa1 = 9; tick();
      idle(); set_busy = 1; set_addr = 0; tick();
      idle(); #1;
      chk("set_r0_cnt", DW'(busy_cnt), 32'h0);
      tick();
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 127) == 0);
         we0 = $urandom_range(0, 1) == 1; wa0 = rnd_addr(); wd0 = $urandom;
         we1 = $urandom_range(0, 2) == 0; wa1 = rnd_addr(); wd1 = $urandom;
         set_busy = $urandom_range(0, 2) == 0; set_addr = rnd_addr();
         for (int k = 0; k < RP; k++) ra[k*AW +: AW] = rnd_addr();
         tick();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read, dual-write general-purpose register file with write-through bypass and a per-register pending-write scoreboard. It replaces the single-write, two-read register file in the CPU datapath. Write port 0 carries ALU writeback; write port 1 carries load/memory writeback. The scoreboard lets decode stall on registers whose load result has not yet returned. Entry 0 is hard-wired zero, is never written, and is never busy.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: address width; depth = 2**ADDR_W entries, entry 0 constant zero.
- RD_PORTS, 2: number of independent read ports (1..4).
- BYPASS, 1: 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset, sampled on rising clk.
- we0  in  1  write enable, port 0 (ALU writeback).
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (memory writeback); also clears busy.
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- ra  in  RD_PORTS*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd  out  RD_PORTS*DATA_W  packed read data, same packing.
- rbusy  out  RD_PORTS  per-port busy flag for the addressed register.
- set_busy  in  1  mark register set_addr pending (load issued).
- set_addr  in  ADDR_W  register to mark pending.
- busy_cnt  out  ADDR_W+1  number of currently busy registers.

## Operation
- Storage: entries 1..2**ADDR_W-1 of DATA_W bits, plus one busy bit each. Entry 0 has no storage and its busy bit is constant 0.
- Reset (rst=1 at edge): all entries clear to 0, all busy bits clear to 0, busy_cnt clears to 0. Writes and set_busy in that cycle are ignored.
- Write: an enabled port with a nonzero address updates the entry at the edge. A write to address 0 is dropped.
- Write collision (we0 & we1 & wa0==wa1): port 1 data is stored; port 0 is discarded.
- Read (combinational): ra=0 gives rd=0.
  - BYPASS=1: if we1 & wa1==ra & ra!=0, rd=wd1; else if we0 & wa0==ra & ra!=0, rd=wd0; else rd is the stored value.
  - BYPASS=0: rd is always the stored value.
- Scoreboard, per edge:
  - we1 with wa1!=0 clears busy[wa1].
  - set_busy with set_addr!=0 sets busy[set_addr].
  - Same address set and cleared in one cycle: set wins (a new load supersedes the returning one).
  - Port 0 writes never touch busy bits.
- rbusy[k] = busy[ra_k] from registered state. It is not bypassed: a clear landing this cycle still reads busy=1 until the next edge.
- busy_cnt is registered and tracks the popcount of busy bits.
  - Increments on a 0→1 transition and decrements on a 1→0 transition in the same edge as the bit change.
  - Setting an already busy register or clearing an idle one leaves the count unchanged.
  - Simultaneous set of A and clear of B (A!=B, A idle, B busy) leaves the count unchanged.

## Timing
- Read latency 0 cycles (combinational from ra, storage, and bypass inputs).
- Write latency 1 edge to storage. With BYPASS=1 the data is visible on rd in the same cycle as the write.
- Busy update 1 edge after set_busy or we1; rbusy reflects it from the next cycle.
- After rst deasserts: rd=0 for every address, rbusy=0, busy_cnt=0 until the first write or set.
- Asserting rst mid-operation discards all pending state, including set_busy and writes presented in the reset cycle.
- No combinational path from set_busy or we to rbusy or busy_cnt.

## Test plan
- Reset then read: write 0xDEADBEEF to r5, then assert rst one cycle. Reading r5 gives 0, rbusy=0, busy_cnt=0.
- Zero register: we0=1, wa0=0, wd0=0xFFFFFFFF. ra=0 gives rd=0 in the same and the following cycle, on all ports.
- Collision and bypass (BYPASS=1): we0 r3=0x11, we1 r3=0x22 in the same cycle. rd(r3)=0x22 in that cycle and stays 0x22 afterward. With BYPASS=0, rd shows the old value in that cycle and 0x22 the next.
- Multi-port read (RD_PORTS=4): preload r1..r4 with 0xA1..0xA4. Present ra={r4,r3,r2,r1} in one cycle; rd returns {0xA4,0xA3,0xA2,0xA1}.
- Scoreboard lifecycle: set_busy r7 gives rbusy=1 and busy_cnt=1 next cycle. Then we1 r7=0x55: rbusy stays 1 that cycle (no bypass), then goes 0 and busy_cnt=0 the next cycle; rd(r7)=0x55.
- Set/clear race: with r9 busy, assert set_busy r9 and we1 r9 in the same cycle. r9 stays busy and busy_cnt is unchanged. set_busy r0 leaves busy_cnt at 0.
